// File: rtl/mult_booth_if.sv
// Start/result handshake between the control FSM and the Booth multiplier.
interface mult_booth_if #(
   parameter int WIDTH = 32
);
   logic             comeco;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] himult;
   logic [WIDTH-1:0] lomult;
   logic             pronto;
   logic             ocupado;

   modport master (
      output comeco, A, B,
      input  himult, lomult, pronto, ocupado
   );

   modport slave (
      input  comeco, A, B,
      output himult, lomult, pronto, ocupado
   );
endinterface

// File: rtl/mult_booth.sv
// Multicycle signed WIDTHxWIDTH -> 2*WIDTH multiplier, radix-2 Booth, one bit per cycle.
// Fixed latency of WIDTH+2 edges from the accepted start to the pronto pulse.
module mult_booth #(
   parameter int WIDTH = 32
) (
   input  logic         clock,
   input  logic         reset,
   mult_booth_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ESPERA   = 2'd0,
      INICIAL  = 2'd1,
      CONTAGEM = 2'd2,
      FIM      = 2'd3
   } state_t;

   state_t           state_q, state_d;
   // acc and M carry one extra bit so that subtracting M = -2^(W-1) cannot overflow
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH:0]   m_q, m_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] q_q, q_d;
   logic             q1_q, q1_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             pronto_q, pronto_d;
   logic             ocupado;

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ESPERA;
      else        state_q <= state_d;
   end

   // next-state: start only from ESPERA; leave CONTAGEM after WIDTH iterations
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ESPERA:   if (bus.comeco) state_d = INICIAL;
         INICIAL:  state_d = CONTAGEM;
         CONTAGEM: if (cnt_q == CW'(WIDTH - 1)) state_d = FIM;
         FIM:      state_d = ESPERA;
         default:  state_d = ESPERA;
      endcase
   end

   // FSM outputs: busy flag and the one-cycle done pulse (registered)
   always_comb begin
      ocupado  = (state_q != ESPERA);
      pronto_d = (state_q == FIM);
   end

   // Booth recoding of {Q[0], q_1}: 01 adds M, 10 subtracts M
   always_comb begin
      unique case ({q_q[0], q1_q})
         2'b01:   sum = acc_q + m_q;
         2'b10:   sum = acc_q - m_q;
         default: sum = acc_q;
      endcase
   end

   // datapath next-state: load operands, iterate with arithmetic shift, capture result
   always_comb begin
      acc_d = acc_q;
      m_d   = m_q;
      q_d   = q_q;
      q1_d  = q1_q;
      cnt_d = cnt_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      unique case (state_q)
         INICIAL: begin
            acc_d = '0;
            m_d   = {bus.A[WIDTH-1], bus.A};
            q_d   = bus.B;
            q1_d  = 1'b0;
            cnt_d = '0;
         end
         CONTAGEM: begin
            acc_d = {sum[WIDTH], sum[WIDTH:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q + CW'(1);
         end
         FIM: begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = q_q;
         end
         default: ;
      endcase
   end

   // datapath registers; reset discards any operation in flight
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q    <= '0;
         m_q      <= '0;
         q_q      <= '0;
         q1_q     <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         pronto_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         m_q      <= m_d;
         q_q      <= q_d;
         q1_q     <= q1_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         pronto_q <= pronto_d;
      end
   end

   assign bus.himult  = hi_q;
   assign bus.lomult  = lo_q;
   assign bus.pronto  = pronto_q;
   assign bus.ocupado = ocupado;

endmodule

// File: tb/tb_mult_booth.sv
// Randomized and directed check of mult_booth against a plain signed-multiply model.
module tb_mult_booth;
   localparam int W = 32;
   localparam int LAT = W + 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   mult_booth_if #(.WIDTH(W)) bus ();
   mult_booth #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
   endfunction

   // present operands with comeco; returns #1 after the accepting edge
   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
      @(negedge clock);
      bus.A = a;
      bus.B = b;
      bus.comeco = 1'b1;
      @(posedge clock);
      #1;
      if (!hold) bus.comeco = 1'b0;
   endtask

   // count edges until pronto; optionally scramble A/B after INICIAL and pulse comeco mid-run
   task automatic wait_pronto(output int n, input bit scramble, input int pulse_at);
      bit got;
      n = 0;
      got = 0;
      while (!got && n < 100) begin
         @(posedge clock);
         n++;
         #1;
         if (scramble && n == 1) begin
            bus.A = $urandom;
            bus.B = $urandom;
         end
         if (n == pulse_at) bus.comeco = 1'b1;
         else if (pulse_at > 0 && n == pulse_at + 1) bus.comeco = 1'b0;
         if (n == 5) chk("busy", 64'(bus.ocupado), 64'd1);
         if (bus.pronto === 1'b1) got = 1;
      end
      if (!got) chk("timeout", 64'd0, 64'd1);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      int n;
      logic [63:0] exp;
      exp = ref_mul(a, b);
      start(a, b, 1'b0);
      wait_pronto(n, 1'b1, -1);
      chk({tag, "_lat"}, 64'(n), 64'(LAT));
      chk({tag, "_prod"}, {bus.himult, bus.lomult}, exp);
      @(posedge clock);
      #1;
      chk({tag, "_pulse"}, {62'd0, bus.pronto, bus.ocupado}, 64'd0);
      chk({tag, "_hold"}, {bus.himult, bus.lomult}, exp);
   endtask

   initial begin
      int n, cnt_p, cnt_b;
      logic [W-1:0] da [6];
      logic [W-1:0] db [6];
      logic [W-1:0] ra, rb;

      bus.comeco = 1'b0;
      bus.A = '0;
      bus.B = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_res", {bus.himult, bus.lomult}, 64'd0);
      chk("rst_flags", {62'd0, bus.pronto, bus.ocupado}, 64'd0);
      @(negedge clock);
      reset = 1'b1;

      // directed corners
      da = '{32'd3, 32'hFFFF_FFF9, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0};
      db = '{32'd5, 32'd6,         32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
      for (int i = 0; i < 6; i++) run_op(da[i], db[i], $sformatf("dir%0d", i));
      // literal expectations for the two extreme cases
      run_op(32'h8000_0000, 32'h8000_0000, "minmin");
      chk("minmin_lit", {bus.himult, bus.lomult}, 64'h4000_0000_0000_0000);
      run_op(32'hFFFF_FFF9, 32'd6, "neg7x6");
      chk("neg7x6_lit", {bus.himult, bus.lomult}, 64'hFFFF_FFFF_FFFF_FFD6);

      // random operands, occasionally forced to extremes
      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 5 == 1) ra = 32'h8000_0000;
         if (i % 7 == 2) rb = 32'h7FFF_FFFF;
         run_op(ra, rb, $sformatf("rnd%0d", i));
      end

      // async reset at iteration 10 discards the operation
      start(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      repeat (11) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      chk("mid_rst_res", {bus.himult, bus.lomult}, 64'd0);
      chk("mid_rst_flags", {62'd0, bus.pronto, bus.ocupado}, 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      cnt_p = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (bus.pronto === 1'b1) cnt_p++;
      end
      chk("rst_no_pronto", 64'(cnt_p), 64'd0);
      run_op(32'd2, 32'd2, "after_rst");
      chk("after_rst_lit", {bus.himult, bus.lomult}, 64'd4);

      // comeco pulsed while busy is ignored
      ra = $urandom;
      rb = $urandom;
      start(ra, rb, 1'b0);
      wait_pronto(n, 1'b1, 10);
      chk("ign_lat", 64'(n), 64'(LAT));
      chk("ign_prod", {bus.himult, bus.lomult}, ref_mul(ra, rb));
      cnt_p = 0;
      cnt_b = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (bus.pronto === 1'b1) cnt_p++;
         if (bus.ocupado === 1'b1) cnt_b++;
      end
      chk("ign_no_pronto", 64'(cnt_p), 64'd0);
      chk("ign_no_busy", 64'(cnt_b), 64'd0);

      // comeco held high: back-to-back operations
      ra = $urandom;
      rb = $urandom;
      start(ra, rb, 1'b1);
      wait_pronto(n, 1'b1, -1);
      chk("b2b1_lat", 64'(n), 64'(LAT));
      chk("b2b1_prod", {bus.himult, bus.lomult}, ref_mul(ra, rb));
      ra = $urandom;
      rb = $urandom;
      bus.A = ra;
      bus.B = rb;
      wait_pronto(n, 1'b0, -1);
      bus.comeco = 1'b0;
      chk("b2b2_gap", 64'(n), 64'(W + 3));
      chk("b2b2_prod", {bus.himult, bus.lomult}, ref_mul(ra, rb));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
